// File: rtl/rgmii_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// rgmii_tx_arbiter_if
//   Bundles the N_PORTS requester AXI-Stream inputs and the single AXI-Stream
//   output towards the RGMII MAC core tx_axis_* port.
//
//   Signals
//     s_axis_tdata   8*N_PORTS  per-requester byte, port i at [8*i+7:8*i]
//     s_axis_tvalid  N_PORTS    per-requester valid
//     s_axis_tlast   N_PORTS    per-requester end of packet
//     s_axis_tuser   N_PORTS    per-requester bad-frame flag
//     s_axis_tready  N_PORTS    per-requester ready (driven by the arbiter)
//     m_axis_tdata   8          byte to the MAC
//     m_axis_tvalid  1          valid to the MAC
//     m_axis_tready  1          ready from the MAC
//     m_axis_tlast   1          end of packet to the MAC
//     m_axis_tuser   1          bad-frame flag to the MAC
//
//   Modports
//     master : the arbiter (drives m_axis_* and s_axis_tready)
//     slave  : the environment (requesters and MAC)
// ---------------------------------------------------------------------------
interface rgmii_tx_arbiter_if #(
    parameter int N_PORTS = 2
);
    logic [8*N_PORTS-1:0] s_axis_tdata;
    logic [N_PORTS-1:0]   s_axis_tvalid;
    logic [N_PORTS-1:0]   s_axis_tlast;
    logic [N_PORTS-1:0]   s_axis_tuser;
    logic [N_PORTS-1:0]   s_axis_tready;

    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 m_axis_tuser;

    modport master (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        input  s_axis_tuser,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast,
        output m_axis_tuser
    );

    modport slave (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        output s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast,
        input  m_axis_tuser
    );
endinterface

// File: rtl/rgmii_tx_arbiter.sv
// ---------------------------------------------------------------------------
// rgmii_tx_arbiter
//   Packet-granular round-robin arbiter that shares the single 8-bit TX
//   AXI-Stream input of the RGMII MAC core between N_PORTS requesters.
//   Whole packets are forwarded without interleaving. A packet whose source
//   stalls mid-frame for TIMEOUT cycles is terminated towards the MAC with a
//   zero byte flagged tlast/tuser, and the rest of that source's packet is
//   then silently drained.
//
//   Parameters
//     N_PORTS  number of requesters, 2..8
//     TIMEOUT  consecutive mid-packet cycles with the owner's tvalid low
//              before the packet is aborted, >= 2
//
//   Ports
//     clk_int    125 MHz TX clock, the only clock
//     rst_int_n  asynchronous active-low reset
//     bus        AXI-Stream bundle (requesters in, MAC out), master modport
//     grant      one-hot current owner, 0 while idle
//     abort_cnt  saturating count of aborted packets
// ---------------------------------------------------------------------------
module rgmii_tx_arbiter #(
    parameter int N_PORTS = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk_int,
    input  logic                  rst_int_n,
    rgmii_tx_arbiter_if.master    bus,
    output logic [N_PORTS-1:0]    grant,
    output logic [15:0]           abort_cnt
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [N_PORTS-1:0] grant_n;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_n;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_n;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_n;
    logic [15:0]        abort_cnt_n;

    logic [IDX_W-1:0]   pick;
    logic               pick_vld;
    logic               own_vld;
    logic               own_last;

    // Index of the k-th candidate when searching round-robin from base.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int               k);
        int s;
        s = int'(base) + k;
        if (s >= N_PORTS) begin
            s = s - N_PORTS;
        end
        return IDX_W'(s);
    endfunction

    // Port after g, wrapping at N_PORTS (which need not be a power of two).
    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(N_PORTS - 1)) ? '0 : g + IDX_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    assign own_vld  = bus.s_axis_tvalid[owner];
    assign own_last = bus.s_axis_tlast[owner];

    // First requesting port at or after rr_ptr. The previous owner was moved
    // past when its packet finished, so it is searched last.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!pick_vld && bus.s_axis_tvalid[rr_index(rr_ptr, k)]) begin
                pick     = rr_index(rr_ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state and output decode. Outputs depend only on the registered
    // state/owner plus the owner's live stream signals, so reset forces all
    // of them low immediately.
    always_comb begin
        state_n     = state;
        grant_n     = grant;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        timer_n     = '0;
        abort_cnt_n = abort_cnt;

        bus.s_axis_tready = '0;
        bus.m_axis_tdata  = 8'h00;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tuser  = 1'b0;

        unique case (state)
            IDLE: begin
                // Selecting cycle: nothing is consumed, which yields the
                // one-cycle bubble between packets.
                if (pick_vld) begin
                    state_n       = PASS;
                    owner_n       = pick;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                end
            end

            PASS: begin
                bus.m_axis_tdata          = bus.s_axis_tdata[{owner, 3'b000} +: 8];
                bus.m_axis_tvalid         = own_vld;
                bus.m_axis_tlast          = own_last;
                bus.m_axis_tuser          = bus.s_axis_tuser[owner];
                bus.s_axis_tready[owner]  = bus.m_axis_tready;

                // Only source starvation counts towards the timeout; MAC
                // backpressure with tvalid high keeps the timer at zero.
                // A final handshake always wins over an expiring timer.
                if (own_vld && bus.m_axis_tready && own_last) begin
                    state_n  = IDLE;
                    grant_n  = '0;
                    rr_ptr_n = next_port(owner);
                end else if (own_vld) begin
                    timer_n = '0;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    state_n = ABORT;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            ABORT: begin
                // Synthetic terminating beat; held until the MAC accepts it.
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tdata  = 8'h00;
                bus.m_axis_tlast  = 1'b1;
                bus.m_axis_tuser  = 1'b1;
                if (bus.m_axis_tready) begin
                    state_n     = DRAIN;
                    abort_cnt_n = sat_inc(abort_cnt);
                end
            end

            DRAIN: begin
                // Swallow the remainder of the aborted packet; the MAC has
                // already seen its end.
                bus.s_axis_tready[owner] = 1'b1;
                if (own_vld && own_last) begin
                    state_n  = IDLE;
                    grant_n  = '0;
                    rr_ptr_n = next_port(owner);
                end
            end

            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            timer     <= '0;
            abort_cnt <= 16'h0000;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            timer     <= timer_n;
            abort_cnt <= abort_cnt_n;
        end
    end

endmodule

// File: tb/tb_rgmii_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rgmii_tx_arbiter
//   Directed bench for rgmii_tx_arbiter with N_PORTS=2, TIMEOUT=16.
//   Inputs change 1 ns after the rising edge; outputs are checked on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_rgmii_tx_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic          clk_int = 1'b0;
    logic          rst_int_n;
    logic [N-1:0]  grant;
    logic [15:0]   abort_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] t1_bytes [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] t3_bytes [6]  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    logic [7:0] t2_exp   [12] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h02, 8'h03,
                                  8'h12, 8'h13, 8'h04, 8'h05, 8'h14, 8'h15};

    int         idx;
    int         oi;
    int         sp [2];
    logic [1:0] hs;
    logic       rdy;
    logic       bubble_due;
    logic [1:0] exp_g;

    rgmii_tx_arbiter_if #(.N_PORTS(N)) bus ();

    rgmii_tx_arbiter #(
        .N_PORTS (N),
        .TIMEOUT (TO)
    ) dut (
        .clk_int   (clk_int),
        .rst_int_n (rst_int_n),
        .bus       (bus),
        .grant     (grant),
        .abort_cnt (abort_cnt)
    );

    always #4 clk_int = ~clk_int;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [7:0] d,
                            input logic l, input logic u);
        bus.s_axis_tvalid[p]       = v;
        bus.s_axis_tdata[8*p +: 8] = d;
        bus.s_axis_tlast[p]        = l;
        bus.s_axis_tuser[p]        = u;
    endtask

    task automatic step();
        @(posedge clk_int);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_int);
    endtask

    initial begin
        rst_int_n         = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tuser  = '0;
        bus.m_axis_tready = 1'b0;
        step();
        step();

        // ---------------- reset state ----------------
        mid();
        check("rst_grant",  32'(grant), 32'h0);
        check("rst_sready", 32'(bus.s_axis_tready), 32'h0);
        check("rst_mvalid", 32'(bus.m_axis_tvalid), 32'h0);
        check("rst_mlast",  32'(bus.m_axis_tlast), 32'h0);
        check("rst_muser",  32'(bus.m_axis_tuser), 32'h0);
        check("rst_mdata",  32'(bus.m_axis_tdata), 32'h0);
        check("rst_abort",  32'(abort_cnt), 32'h0);
        step();
        rst_int_n = 1'b1;

        // ---------------- 1: port0 4-byte packet ----------------
        bus.m_axis_tready = 1'b1;
        set_port(0, 1'b1, 8'h11, 1'b0, 1'b0);
        mid();
        check("t1_sel_grant",  32'(grant), 32'h0);
        check("t1_sel_mvalid", 32'(bus.m_axis_tvalid), 32'h0);
        check("t1_sel_sready", 32'(bus.s_axis_tready), 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, t1_bytes[i], (i == 3), 1'b0);
            mid();
            check("t1_grant",  32'(grant), 32'h1);
            check("t1_mdata",  32'(bus.m_axis_tdata), 32'(t1_bytes[i]));
            check("t1_mvalid", 32'(bus.m_axis_tvalid), 32'h1);
            check("t1_mlast",  32'(bus.m_axis_tlast), 32'(i == 3));
            check("t1_sready", 32'(bus.s_axis_tready), 32'h1);
            step();
        end
        set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
        mid();
        check("t1_end_grant",  32'(grant), 32'h0);
        check("t1_end_mvalid", 32'(bus.m_axis_tvalid), 32'h0);
        step();

        // ---------------- 5: tuser on last beat ----------------
        set_port(0, 1'b1, 8'h55, 1'b0, 1'b0);
        mid();
        check("t5_sel_grant", 32'(grant), 32'h0);
        step();
        mid();
        check("t5_b0_grant", 32'(grant), 32'h1);
        check("t5_b0_mdata", 32'(bus.m_axis_tdata), 32'h55);
        check("t5_b0_muser", 32'(bus.m_axis_tuser), 32'h0);
        check("t5_b0_mlast", 32'(bus.m_axis_tlast), 32'h0);
        step();
        set_port(0, 1'b1, 8'h66, 1'b1, 1'b1);
        mid();
        check("t5_b1_mdata", 32'(bus.m_axis_tdata), 32'h66);
        check("t5_b1_muser", 32'(bus.m_axis_tuser), 32'h1);
        check("t5_b1_mlast", 32'(bus.m_axis_tlast), 32'h1);
        step();
        set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
        mid();
        check("t5_end_grant", 32'(grant), 32'h0);
        check("t5_end_muser", 32'(bus.m_axis_tuser), 32'h0);
        check("t5_end_abort", 32'(abort_cnt), 32'h0);
        step();

        // ---------------- 3: port1 6 bytes under toggling backpressure ----------------
        set_port(1, 1'b1, t3_bytes[0], 1'b0, 1'b0);
        mid();
        check("t3_sel_grant", 32'(grant), 32'h0);
        step();
        idx = 0;
        for (int k = 0; k < 16 && idx < 6; k++) begin
            rdy = ((k % 2) == 0);
            bus.m_axis_tready = rdy;
            set_port(1, 1'b1, t3_bytes[idx], (idx == 5), 1'b0);
            mid();
            check("t3_mdata",  32'(bus.m_axis_tdata), 32'(t3_bytes[idx]));
            check("t3_mvalid", 32'(bus.m_axis_tvalid), 32'h1);
            check("t3_sready", 32'(bus.s_axis_tready), 32'({rdy, 1'b0}));
            check("t3_grant",  32'(grant), 32'h2);
            check("t3_timer",  32'(dut.timer), 32'h0);
            step();
            if (rdy) idx++;
        end
        check("t3_count", 32'(idx), 32'd6);
        set_port(1, 1'b0, 8'h00, 1'b0, 1'b0);
        bus.m_axis_tready = 1'b1;
        mid();
        check("t3_end_grant", 32'(grant), 32'h0);
        step();

        // ---------------- 2: both ports, three 2-byte packets each ----------------
        rst_int_n = 1'b0;
        step();
        rst_int_n = 1'b1;
        sp[0] = 0;
        sp[1] = 0;
        oi = 0;
        bubble_due = 1'b0;
        for (int cyc = 0; cyc < 40 && oi < 12; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (sp[p] < 6) set_port(p, 1'b1, 8'((p << 4) | sp[p]), ((sp[p] % 2) == 1), 1'b0);
                else           set_port(p, 1'b0, 8'h00, 1'b0, 1'b0);
            end
            mid();
            hs = bus.s_axis_tvalid & bus.s_axis_tready;
            if (bubble_due) begin
                check("t2_bubble", 32'(bus.m_axis_tvalid), 32'h0);
                bubble_due = 1'b0;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                exp_g = (t2_exp[oi][7:4] == 4'h0) ? 2'b01 : 2'b10;
                check("t2_mdata", 32'(bus.m_axis_tdata), 32'(t2_exp[oi]));
                check("t2_grant", 32'(grant), 32'(exp_g));
                check("t2_mlast", 32'(bus.m_axis_tlast), 32'((oi % 2) == 1));
                if (bus.m_axis_tlast) bubble_due = 1'b1;
                oi++;
            end
            step();
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) sp[p]++;
            end
        end
        check("t2_count", 32'(oi), 32'd12);
        set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_port(1, 1'b0, 8'h00, 1'b0, 1'b0);
        mid();
        check("t2_end_grant", 32'(grant), 32'h0);
        step();

        // ---------------- 4: stall timeout, abort, drain ----------------
        set_port(0, 1'b1, 8'hAA, 1'b0, 1'b0);
        set_port(1, 1'b1, 8'h77, 1'b1, 1'b0);
        mid();
        check("t4_sel_grant", 32'(grant), 32'h0);
        step();
        mid();
        check("t4_aa_grant", 32'(grant), 32'h1);
        check("t4_aa_mdata", 32'(bus.m_axis_tdata), 32'hAA);
        step();
        set_port(0, 1'b1, 8'hBB, 1'b0, 1'b0);
        mid();
        check("t4_bb_mdata", 32'(bus.m_axis_tdata), 32'hBB);
        step();
        set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int s = 1; s <= TO; s++) begin
            mid();
            check("t4_stall_mvalid", 32'(bus.m_axis_tvalid), 32'h0);
            check("t4_stall_grant",  32'(grant), 32'h1);
            if (s == TO) check("t4_stall_timer", 32'(dut.timer), 32'(TO - 1));
            step();
        end
        bus.m_axis_tready = 1'b0;
        mid();
        check("t4_abort_mvalid", 32'(bus.m_axis_tvalid), 32'h1);
        check("t4_abort_mdata",  32'(bus.m_axis_tdata), 32'h0);
        check("t4_abort_mlast",  32'(bus.m_axis_tlast), 32'h1);
        check("t4_abort_muser",  32'(bus.m_axis_tuser), 32'h1);
        check("t4_abort_sready", 32'(bus.s_axis_tready), 32'h0);
        check("t4_abort_cnt0",   32'(abort_cnt), 32'h0);
        step();
        bus.m_axis_tready = 1'b1;
        mid();
        check("t4_hold_mvalid", 32'(bus.m_axis_tvalid), 32'h1);
        check("t4_hold_mlast",  32'(bus.m_axis_tlast), 32'h1);
        check("t4_hold_muser",  32'(bus.m_axis_tuser), 32'h1);
        step();
        mid();
        check("t4_drain_mvalid", 32'(bus.m_axis_tvalid), 32'h0);
        check("t4_drain_sready", 32'(bus.s_axis_tready), 32'h1);
        check("t4_drain_cnt",    32'(abort_cnt), 32'h1);
        check("t4_drain_grant",  32'(grant), 32'h1);
        step();
        mid();
        step();
        set_port(0, 1'b1, 8'hCC, 1'b0, 1'b0);
        mid();
        check("t4_cc_mvalid", 32'(bus.m_axis_tvalid), 32'h0);
        check("t4_cc_sready", 32'(bus.s_axis_tready), 32'h1);
        step();
        set_port(0, 1'b1, 8'hDD, 1'b1, 1'b0);
        mid();
        check("t4_dd_mvalid", 32'(bus.m_axis_tvalid), 32'h0);
        step();
        set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
        mid();
        check("t4_idle_grant", 32'(grant), 32'h0);
        step();
        mid();
        check("t4_p1_grant",  32'(grant), 32'h2);
        check("t4_p1_mdata",  32'(bus.m_axis_tdata), 32'h77);
        check("t4_p1_mlast",  32'(bus.m_axis_tlast), 32'h1);
        check("t4_p1_mvalid", 32'(bus.m_axis_tvalid), 32'h1);
        check("t4_p1_cnt",    32'(abort_cnt), 32'h1);
        step();
        set_port(1, 1'b0, 8'h00, 1'b0, 1'b0);
        mid();
        check("t4_end_grant", 32'(grant), 32'h0);
        step();

        // ---------------- 6: reset mid-packet ----------------
        set_port(0, 1'b1, 8'h31, 1'b0, 1'b0);
        mid();
        step();
        mid();
        check("t6_pass_grant",  32'(grant), 32'h1);
        check("t6_pass_mvalid", 32'(bus.m_axis_tvalid), 32'h1);
        step();
        set_port(0, 1'b1, 8'h32, 1'b0, 1'b0);
        rst_int_n = 1'b0;
        #1;
        check("t6_rst_grant",  32'(grant), 32'h0);
        check("t6_rst_sready", 32'(bus.s_axis_tready), 32'h0);
        check("t6_rst_mvalid", 32'(bus.m_axis_tvalid), 32'h0);
        check("t6_rst_abort",  32'(abort_cnt), 32'h0);
        set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_port(1, 1'b1, 8'h41, 1'b1, 1'b0);
        step();
        rst_int_n = 1'b1;
        mid();
        check("t6_sel_grant", 32'(grant), 32'h0);
        step();
        mid();
        check("t6_p1_grant", 32'(grant), 32'h2);
        check("t6_p1_mdata", 32'(bus.m_axis_tdata), 32'h41);
        step();
        set_port(1, 1'b0, 8'h00, 1'b0, 1'b0);
        mid();
        check("t6_end_grant", 32'(grant), 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
